// File: rtl/rot_pkg.sv
// rot_dma_ctrl shared types: FSM state encoding, HSIZE code and
// default sizing parameters for the burst sequencer.
package rot_pkg;

  localparam int MAX_BURST_DEF = 16;
  localparam int LEN_W_DEF = 16;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_PROC_REQ,
    S_PROC_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FIN
  } rdc_state_e;

endpackage

// File: rtl/rot_burst_calc.sv
// Chunk sizing and address advance for rot_dma_ctrl: retires one chunk
// from the job and sizes the next one as min(remaining, MAX_BURST).
module rot_burst_calc
  import rot_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic [LEN_W-1:0] rem_i,
  input  logic [4:0]       chunk_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  output logic [LEN_W-1:0] rem_o,
  output logic [4:0]       chunk_o,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o
);

  logic [31:0] step;

  always_comb begin
    step  = {25'd0, chunk_i, 2'b00};
    src_o = src_i + step;
    dst_o = dst_i + step;
    rem_o = rem_i - LEN_W'(chunk_i);
    if (rem_o > LEN_W'(MAX_BURST)) begin
      chunk_o = 5'(MAX_BURST);
    end else begin
      chunk_o = rem_o[4:0];
    end
  end

endmodule

// File: rtl/rot_dma_ctrl.sv
// Frame job sequencer for the rotate path: read burst, pixel engine, write burst.
// Optional RDC_PERF_CNT_EN adds O_RDC_CYCLES / O_RDC_BURSTS job counters.
module rot_dma_ctrl
  import rot_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             I_RDC_HCLK,
  input  logic             I_RDC_RESET,
  input  logic             I_RDC_START,
  input  logic             I_RDC_ABORT,
  input  logic [31:0]      I_RDC_SRC_ADDR,
  input  logic [31:0]      I_RDC_DST_ADDR,
  input  logic [LEN_W-1:0] I_RDC_LEN,
  input  logic             I_RDC_DMA_DONE,
  input  logic             I_RDC_PROC_DONE,
  output logic [31:0]      O_RDC_DMA_ADDR,
  output logic [4:0]       O_RDC_DMA_COUNT,
  output logic [2:0]       O_RDC_DMA_SIZE,
  output logic             O_RDC_DMA_WRITE,
  output logic             O_RDC_DMA_START,
  output logic             O_RDC_PROC_START,
  output logic [4:0]       O_RDC_PROC_COUNT,
  output logic             O_RDC_BUSY,
  output logic             O_RDC_DONE,
  output logic             O_RDC_ABORTED
`ifdef RDC_PERF_CNT_EN
  ,
  output logic [31:0]      O_RDC_CYCLES,
  output logic [15:0]      O_RDC_BURSTS
`endif
);

  rdc_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [4:0]       chunk_q, chunk_d;
  logic             abort_pend_q, abort_pend_d;

  logic [31:0] dma_addr_q, dma_addr_d;
  logic [4:0]  dma_count_q, dma_count_d;
  logic        dma_write_q, dma_write_d;
  logic        dma_start_q, dma_start_d;
  logic        proc_start_q, proc_start_d;
  logic [4:0]  proc_count_q, proc_count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic             idle;
  logic             stop;
  logic [LEN_W-1:0] c_rem_i, c_rem_o;
  logic [4:0]       c_chunk_i, c_chunk_o;
  logic [31:0]      c_src_i, c_src_o;
  logic [31:0]      c_dst_i, c_dst_o;

  assign idle = (state_q == S_IDLE);

  // In IDLE the calculator sizes the first chunk straight from the job inputs.
  always_comb begin
    if (idle) begin
      c_rem_i   = I_RDC_LEN;
      c_chunk_i = 5'd0;
      c_src_i   = I_RDC_SRC_ADDR & ~32'h3;
      c_dst_i   = I_RDC_DST_ADDR & ~32'h3;
    end else begin
      c_rem_i   = rem_q;
      c_chunk_i = chunk_q;
      c_src_i   = src_q;
      c_dst_i   = dst_q;
    end
  end

  rot_burst_calc #(
    .MAX_BURST(MAX_BURST),
    .LEN_W    (LEN_W)
  ) u_calc (
    .rem_i  (c_rem_i),
    .chunk_i(c_chunk_i),
    .src_i  (c_src_i),
    .dst_i  (c_dst_i),
    .rem_o  (c_rem_o),
    .chunk_o(c_chunk_o),
    .src_o  (c_src_o),
    .dst_o  (c_dst_o)
  );

  assign stop = I_RDC_ABORT | abort_pend_q;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    chunk_d      = chunk_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (I_RDC_START) begin
          src_d   = c_src_o;
          dst_d   = c_dst_o;
          rem_d   = I_RDC_LEN;
          chunk_d = c_chunk_o;
          state_d = (I_RDC_LEN == '0) ? S_FIN : S_RD_REQ;
        end
      end
      S_RD_REQ, S_PROC_REQ, S_WR_REQ: begin
        if (I_RDC_ABORT) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (state_q == S_RD_REQ) begin
          state_d = S_RD_WAIT;
        end else if (state_q == S_PROC_REQ) begin
          state_d = S_PROC_WAIT;
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (I_RDC_ABORT) abort_pend_d = 1'b1;
        if (I_RDC_DMA_DONE) begin
          state_d   = stop ? S_IDLE : S_PROC_REQ;
          aborted_d = stop;
        end
      end
      S_PROC_WAIT: begin
        if (I_RDC_ABORT) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (I_RDC_PROC_DONE) begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_WAIT: begin
        if (I_RDC_ABORT) abort_pend_d = 1'b1;
        if (I_RDC_DMA_DONE) begin
          if (stop) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
          end else begin
            src_d   = c_src_o;
            dst_d   = c_dst_o;
            rem_d   = c_rem_o;
            chunk_d = c_chunk_o;
            state_d = (c_rem_o == '0) ? S_FIN : S_RD_REQ;
          end
        end
      end
      S_FIN: begin
        state_d   = S_IDLE;
        aborted_d = I_RDC_ABORT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; burst fields hold until reused.
  always_comb begin
    dma_addr_d   = dma_addr_q;
    dma_count_d  = dma_count_q;
    dma_write_d  = dma_write_q;
    dma_start_d  = 1'b0;
    proc_start_d = 1'b0;
    proc_count_d = proc_count_q;
    if (state_d == S_RD_REQ) begin
      dma_start_d = 1'b1;
      dma_addr_d  = src_d;
      dma_count_d = chunk_d;
      dma_write_d = 1'b0;
    end else if (state_d == S_WR_REQ) begin
      dma_start_d = 1'b1;
      dma_addr_d  = dst_d;
      dma_count_d = chunk_d;
      dma_write_d = 1'b1;
    end else if (state_d == S_PROC_REQ) begin
      proc_start_d = 1'b1;
      proc_count_d = chunk_d;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge I_RDC_HCLK) begin
    if (I_RDC_RESET) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      chunk_q      <= '0;
      abort_pend_q <= 1'b0;
      dma_addr_q   <= '0;
      dma_count_q  <= '0;
      dma_write_q  <= 1'b0;
      dma_start_q  <= 1'b0;
      proc_start_q <= 1'b0;
      proc_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      chunk_q      <= chunk_d;
      abort_pend_q <= abort_pend_d;
      dma_addr_q   <= dma_addr_d;
      dma_count_q  <= dma_count_d;
      dma_write_q  <= dma_write_d;
      dma_start_q  <= dma_start_d;
      proc_start_q <= proc_start_d;
      proc_count_q <= proc_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign O_RDC_DMA_ADDR   = dma_addr_q;
  assign O_RDC_DMA_COUNT  = dma_count_q;
  assign O_RDC_DMA_SIZE   = HSIZE_WORD;
  assign O_RDC_DMA_WRITE  = dma_write_q;
  assign O_RDC_DMA_START  = dma_start_q;
  assign O_RDC_PROC_START = proc_start_q;
  assign O_RDC_PROC_COUNT = proc_count_q;
  assign O_RDC_BUSY       = busy_q;
  assign O_RDC_DONE       = done_q;
  assign O_RDC_ABORTED    = aborted_q;

`ifdef RDC_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;
  logic [15:0] bursts_q, bursts_d;

  always_comb begin
    cycles_d = cycles_q;
    bursts_d = bursts_q;
    if (idle && I_RDC_START) begin
      cycles_d = '0;
      bursts_d = '0;
    end else begin
      if (busy_q && (cycles_q != '1)) cycles_d = cycles_q + 32'd1;
      if (I_RDC_DMA_DONE &&
          ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT))) begin
        bursts_d = bursts_q + 16'd1;
      end
    end
  end

  always_ff @(posedge I_RDC_HCLK) begin
    if (I_RDC_RESET) begin
      cycles_q <= '0;
      bursts_q <= '0;
    end else begin
      cycles_q <= cycles_d;
      bursts_q <= bursts_d;
    end
  end

  assign O_RDC_CYCLES = cycles_q;
  assign O_RDC_BURSTS = bursts_q;
`endif

endmodule

// File: tb/tb_rot_dma_ctrl.sv
// Self-checking bench for rot_dma_ctrl: job table, randomized jobs with a
// chunking reference model, and hand sequences for abort/reset/stray pulses.
`timescale 1ns/1ps
module tb_rot_dma_ctrl;

  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, dma_done, proc_done;
  logic [31:0]   src, dst;
  logic [LW-1:0] len;
  logic [31:0]   o_addr;
  logic [4:0]    o_count, o_pcount;
  logic [2:0]    o_size;
  logic          o_write, o_dstart, o_pstart;
  logic          o_busy, o_done, o_aborted;
`ifdef RDC_PERF_CNT_EN
  logic [31:0]   o_cycles;
  logic [15:0]   o_bursts;
`endif

  always #5 clk = ~clk;

  rot_dma_ctrl dut (
    .I_RDC_HCLK      (clk),
    .I_RDC_RESET     (rst),
    .I_RDC_START     (start),
    .I_RDC_ABORT     (abort),
    .I_RDC_SRC_ADDR  (src),
    .I_RDC_DST_ADDR  (dst),
    .I_RDC_LEN       (len),
    .I_RDC_DMA_DONE  (dma_done),
    .I_RDC_PROC_DONE (proc_done),
    .O_RDC_DMA_ADDR  (o_addr),
    .O_RDC_DMA_COUNT (o_count),
    .O_RDC_DMA_SIZE  (o_size),
    .O_RDC_DMA_WRITE (o_write),
    .O_RDC_DMA_START (o_dstart),
    .O_RDC_PROC_START(o_pstart),
    .O_RDC_PROC_COUNT(o_pcount),
    .O_RDC_BUSY      (o_busy),
    .O_RDC_DONE      (o_done),
    .O_RDC_ABORTED   (o_aborted)
`ifdef RDC_PERF_CNT_EN
    ,
    .O_RDC_CYCLES    (o_cycles),
    .O_RDC_BURSTS    (o_bursts)
`endif
  );

  // kind: 0 read burst, 1 write burst, 2 pixel-engine handoff
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [4:0]  cnt;
  } ev_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          nev;
    logic [31:0] last_rd;
    logic [31:0] last_wr;
    int          last_cnt;
  } vec_t;

  int  n_vec = 0;
  int  n_bad = 0;
  ev_t got_q[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                         input int l, input bit noise);
    ev_t         exp_q[$];
    ev_t         cur;
    logic [31:0] a, b;
    int rem, c, cyc, dma_cd, proc_cd, dones, aborts, first_start;
    int busy_cyc, lat_err, stab_err, tail;
    bit want_evt, inflight, ended;
    a = s & ~32'h3;
    b = d & ~32'h3;
    rem = l;
    while (rem > 0) begin
      c = (rem > 16) ? 16 : rem;
      exp_q.push_back(ev_t'{2'd0, a, 5'(c)});
      exp_q.push_back(ev_t'{2'd2, 32'd0, 5'(c)});
      exp_q.push_back(ev_t'{2'd1, b, 5'(c)});
      a = a + 32'(c * 4);
      b = b + 32'(c * 4);
      rem = rem - c;
    end
    got_q.delete();
    cur = '0;
    cyc = 0; dma_cd = 0; proc_cd = 0; dones = 0; aborts = 0;
    first_start = -1; busy_cyc = 0; lat_err = 0; stab_err = 0; tail = 0;
    want_evt = 0; inflight = 0; ended = 0;
    tick;
    start = 1'b1; src = s; dst = d; len = LW'(l);
    while (cyc < 2000 && tail < 6) begin
      tick;
      cyc++;
      start = 1'b0; dma_done = 1'b0; proc_done = 1'b0;
      if (o_busy) busy_cyc++;
      if (want_evt && !(o_dstart || o_pstart || o_done)) lat_err++;
      want_evt = 0;
      if (inflight && (o_addr !== cur.addr || o_count !== cur.cnt ||
                       o_write !== cur.kind[0])) stab_err++;
      if (o_dstart) begin
        cur = ev_t'{{1'b0, o_write}, o_addr, o_count};
        got_q.push_back(cur);
        inflight = 1;
        if (first_start < 0) first_start = cyc;
        dma_cd = 1 + $urandom_range(0, 3);
      end else if (dma_cd > 0) begin
        dma_cd--;
        if (dma_cd == 0) begin
          dma_done = 1'b1; inflight = 0; want_evt = 1;
        end
      end
      if (o_pstart) begin
        got_q.push_back(ev_t'{2'd2, 32'd0, o_pcount});
        proc_cd = 1 + $urandom_range(0, 3);
      end else if (proc_cd > 0) begin
        proc_cd--;
        if (proc_cd == 0) begin
          proc_done = 1'b1; want_evt = 1;
        end
      end
      if (o_done) dones++;
      if (o_aborted) aborts++;
      if (o_done || o_aborted) ended = 1;
      if (ended) begin
        tail++;
      end else if (noise) begin
        if (dma_cd > 0 && $urandom_range(0, 1) == 1) proc_done = 1'b1;
        if (proc_cd > 0 && $urandom_range(0, 1) == 1) dma_done = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          src = $urandom;
          dst = $urandom;
          len = LW'($urandom_range(1, 60));
        end
      end
    end
    start = 1'b0; dma_done = 1'b0; proc_done = 1'b0;
    chk("job_end", 64'(ended), 64'd1);
    chk("ev_count", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) chk($sformatf("ev%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    chk("done_cnt", 64'(dones), 64'd1);
    chk("abort_cnt", 64'(aborts), 64'd0);
    chk("resp_latency", 64'(lat_err), 64'd0);
    chk("burst_stable", 64'(stab_err), 64'd0);
    if (l == 0) chk("len0_busy", 64'(busy_cyc), 64'd1);
    else chk("start_latency", 64'(first_start), 64'd1);
`ifdef RDC_PERF_CNT_EN
    chk("perf_bursts", 64'(o_bursts), 64'(exp_q.size() * 2 / 3));
    if (l == 0) chk("perf_cycles", 64'(o_cycles), 64'd1);
`endif
  endtask

  function automatic logic [31:0] last_addr(input logic [1:0] k);
    logic [31:0] r;
    r = '0;
    foreach (got_q[i]) if (got_q[i].kind == k) r = got_q[i].addr;
    return r;
  endfunction

  vec_t vt[7];
  int   quiet;

  initial begin
    vt[0] = '{32'h0000_1000, 32'h0000_8000, 40, 9, 32'h1080, 32'h8080, 8};
    vt[1] = '{32'h0000_5000, 32'h0000_6000, 0, 0, 32'h0, 32'h0, 0};
    vt[2] = '{32'h0000_1003, 32'h0000_2002, 5, 3, 32'h1000, 32'h2000, 5};
    vt[3] = '{32'hFFFF_FFC0, 32'hFFFF_FFF8, 20, 6, 32'h0, 32'h38, 4};
    vt[4] = '{32'h0000_0040, 32'h0000_0080, 16, 3, 32'h40, 32'h80, 16};
    vt[5] = '{32'h0000_0000, 32'h0000_0400, 17, 6, 32'h40, 32'h440, 1};
    vt[6] = '{32'h0000_0010, 32'h0000_0020, 1, 3, 32'h10, 32'h20, 1};

    rst = 1'b1; start = 0; abort = 0; dma_done = 0; proc_done = 0;
    src = '0; dst = '0; len = '0;
    repeat (3) tick;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_dstart", 64'(o_dstart), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_pstart", 64'(o_pstart), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_size", 64'(o_size), 64'd2);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_job(vt[i].src, vt[i].dst, vt[i].len, 1'b0);
      chk("tbl_nev", 64'(got_q.size()), 64'(vt[i].nev));
      if (vt[i].nev > 0) begin
        chk("tbl_last_rd", 64'(last_addr(2'd0)), 64'(vt[i].last_rd));
        chk("tbl_last_wr", 64'(last_addr(2'd1)), 64'(vt[i].last_wr));
        chk("tbl_last_cnt", 64'(got_q[got_q.size()-1].cnt), 64'(vt[i].last_cnt));
      end
    end

    dma_done = 1'b1;
    tick;
    dma_done = 1'b0;
    tick;
    chk("stray_idle_busy", 64'(o_busy), 64'd0);
    chk("stray_idle_dstart", 64'(o_dstart), 64'd0);

    tick;
    start = 1'b1; src = 32'h3000; dst = 32'h4000; len = LW'(40);
    tick;
    start = 1'b0;
    chk("rdreq_start", 64'(o_dstart), 64'd1);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    repeat (3) begin
      chk("abort_hold_addr", 64'(o_addr), 64'h3000);
      chk("abort_hold_cnt", 64'(o_count), 64'd16);
      chk("abort_hold_busy", 64'(o_busy), 64'd1);
      tick;
    end
    dma_done = 1'b1;
    tick;
    dma_done = 1'b0;
    chk("rdwait_aborted", 64'(o_aborted), 64'd1);
    chk("rdwait_idle", 64'(o_busy), 64'd0);
    quiet = 0;
    repeat (6) begin
      tick;
      if (o_pstart || o_done || o_aborted || o_dstart) quiet++;
    end
    chk("rdwait_quiet", 64'(quiet), 64'd0);

    tick;
    start = 1'b1; src = 32'h500; dst = 32'h600; len = LW'(8);
    tick;
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("rdreq_aborted", 64'(o_aborted), 64'd1);
    chk("rdreq_idle", 64'(o_busy), 64'd0);
    tick;
    chk("abort_one_cycle", 64'(o_aborted), 64'd0);

    tick;
    start = 1'b1; src = 32'h100; dst = 32'h200; len = LW'(10);
    tick;
    start = 1'b0;
    tick;
    dma_done = 1'b1;
    tick;
    dma_done = 1'b0;
    chk("proc_req", 64'(o_pstart), 64'd1);
    chk("proc_cnt", 64'(o_pcount), 64'd10);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("procwait_aborted", 64'(o_aborted), 64'd1);
    chk("procwait_idle", 64'(o_busy), 64'd0);
    quiet = 0;
    repeat (4) begin
      tick;
      if (o_done || o_dstart || o_pstart) quiet++;
    end
    chk("procwait_quiet", 64'(quiet), 64'd0);

    tick;
    start = 1'b1; src = 32'h7000; dst = 32'h9000; len = LW'(20);
    tick;
    start = 1'b0;
    tick;
    dma_done = 1'b1;
    tick;
    dma_done = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_dstart", 64'(o_dstart), 64'd0);
    chk("mid_rst_addr", 64'(o_addr), 64'd0);
    chk("mid_rst_count", 64'(o_count), 64'd0);
    chk("mid_rst_write", 64'(o_write), 64'd0);
    chk("mid_rst_pcount", 64'(o_pcount), 64'd0);
    chk("mid_rst_size", 64'(o_size), 64'd2);
    run_job(32'h7000, 32'h9000, 4, 1'b0);

    run_job(32'h2000, 32'hA000, 50, 1'b1);
    repeat (25) begin
      run_job($urandom, $urandom, $urandom_range(0, 70),
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
